muap_pack: RTL and testbench

- Receives the spike-event (muap) stream from the spike detector: frame number, channel, channel hash and waveform word per event.
- Applies real backpressure through `muap_ready` and buffers events in an internal FIFO.
- Serializes each event into four 32-bit words on an AXI-Stream-style master port for the host DMA.
- Delimits packets with TLAST, either on a fixed event count or through a timeout trailer word.

---
 rtl/muap_pack.sv | 162 ++++++++++++++++
 tb/tb_muap_pack.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muap_pack.sv
// Spike-event packer: buffers muap events in a FIFO and serializes each one into
// four 32-bit stream words, closing packets on an event count or an idle-timeout trailer.
module muap_pack #(
    parameter int FIFO_DEPTH = 16,
    parameter int PKT_EVENTS = 64,
    parameter int TIMEOUT    = 25000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        muap_valid,
    output logic        muap_ready,
    input  logic [31:0] muap_frame_No,
    input  logic [11:0] muap_ch,
    input  logic [31:0] muap_ch_hash,
    input  logic [31:0] muap_data,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [31:0] m_tdata,
    output logic        m_tlast,
    output logic [31:0] pkt_count,
    output logic [31:0] evt_count
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] LAST_IDX  = 16'(PKT_EVENTS - 1);
    localparam logic [23:0] TIMER_MAX = 24'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, W0, W1, W2, W3, TRL} state_t;

    state_t        state_reg;
    logic [107:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg, count_next;
    logic          ready_reg;
    logic          fifo_empty, push, pop;
    logic [107:0]  head;
    logic [75:0]   hold_reg;
    logic [31:0]   tdata_reg, pkt_count_reg, evt_count_reg;
    logic          tvalid_reg, tlast_reg;
    logic [15:0]   evt_in_pkt_reg;
    logic [23:0]   timer_reg;

    assign fifo_empty = (count_reg == '0);
    assign push       = muap_valid && ready_reg;
    assign pop        = !fifo_empty && (state_reg == IDLE || (state_reg == W3 && m_tready));
    assign head       = mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (!push && pop) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {muap_frame_No, muap_ch, muap_ch_hash, muap_data};
        end
    end

    // Ready is registered from the next occupancy so it is 0 throughout reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            ready_reg <= (count_next != DEPTH_C);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            hold_reg       <= '0;
            tdata_reg      <= '0;
            tvalid_reg     <= 1'b0;
            tlast_reg      <= 1'b0;
            evt_in_pkt_reg <= '0;
            timer_reg      <= '0;
            pkt_count_reg  <= '0;
            evt_count_reg  <= '0;
        end else begin
            if (state_reg == IDLE && fifo_empty && evt_in_pkt_reg != '0 && !push
                && timer_reg != TIMER_MAX) begin
                timer_reg <= timer_reg + 1'b1;
            end else begin
                timer_reg <= '0;
            end

            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        hold_reg   <= head[75:0];
                        tdata_reg  <= head[107:76];
                        tvalid_reg <= 1'b1;
                        tlast_reg  <= 1'b0;
                        state_reg  <= W0;
                    // An event arriving on the expiry cycle still beats the trailer.
                    end else if (evt_in_pkt_reg != '0 && timer_reg == TIMER_MAX && !push) begin
                        tdata_reg  <= {16'hFFFF, evt_in_pkt_reg};
                        tvalid_reg <= 1'b1;
                        tlast_reg  <= 1'b1;
                        state_reg  <= TRL;
                    end
                end
                W0: if (m_tready) begin
                    tdata_reg <= {20'h0, hold_reg[75:64]};
                    state_reg <= W1;
                end
                W1: if (m_tready) begin
                    tdata_reg <= hold_reg[63:32];
                    state_reg <= W2;
                end
                W2: if (m_tready) begin
                    tdata_reg <= hold_reg[31:0];
                    tlast_reg <= (evt_in_pkt_reg == LAST_IDX);
                    state_reg <= W3;
                end
                W3: if (m_tready) begin
                    evt_count_reg <= evt_count_reg + 1'b1;
                    if (tlast_reg) begin
                        evt_in_pkt_reg <= '0;
                        pkt_count_reg  <= pkt_count_reg + 1'b1;
                    end else begin
                        evt_in_pkt_reg <= evt_in_pkt_reg + 1'b1;
                    end
                    tlast_reg <= 1'b0;
                    if (!fifo_empty) begin
                        hold_reg  <= head[75:0];
                        tdata_reg <= head[107:76];
                        state_reg <= W0;
                    end else begin
                        tvalid_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                TRL: if (m_tready) begin
                    evt_in_pkt_reg <= '0;
                    pkt_count_reg  <= pkt_count_reg + 1'b1;
                    tvalid_reg     <= 1'b0;
                    tlast_reg      <= 1'b0;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign muap_ready = ready_reg;
    assign m_tvalid   = tvalid_reg;
    assign m_tdata    = tdata_reg;
    assign m_tlast    = tlast_reg;
    assign pkt_count  = pkt_count_reg;
    assign evt_count  = evt_count_reg;
endmodule

// File: tb/tb_muap_pack.sv
// Bench for muap_pack: a word-level scoreboard model plus directed latency,
// packet-boundary, backpressure, timeout-boundary and reset scenarios.
module tb_muap_pack;
    localparam int FD = 4;
    localparam int PE = 4;
    localparam int TO = 8;

    logic        clk, rst;
    logic        muap_valid, muap_ready;
    logic [31:0] muap_frame_No, muap_ch_hash, muap_data;
    logic [11:0] muap_ch;
    logic        m_tvalid, m_tready, m_tlast;
    logic [31:0] m_tdata, pkt_count, evt_count;

    muap_pack #(.FIFO_DEPTH(FD), .PKT_EVENTS(PE), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .muap_valid(muap_valid), .muap_ready(muap_ready),
        .muap_frame_No(muap_frame_No), .muap_ch(muap_ch),
        .muap_ch_hash(muap_ch_hash), .muap_data(muap_data),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tlast(m_tlast), .pkt_count(pkt_count), .evt_count(evt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected output words: kind 0..3 = event word, 4 = trailer.
    typedef struct {
        logic [2:0]  kind;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];
    int open_m = 0, pkt_m = 0, evt_m = 0, idle_m = 0;
    bit stall_prev = 0;
    logic [31:0] prev_data;
    logic        prev_last;

    logic [31:0] log_data[$];
    bit          log_last[$];
    int          log_cyc[$];

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            open_m = 0; pkt_m = 0; evt_m = 0; idle_m = 0;
            stall_prev = 0;
        end else begin
            exp_t e;
            bit   exp_last;
            bit   out_fire, in_fire;
            out_fire = m_tvalid && m_tready;
            in_fire  = muap_valid && muap_ready;
            chk("pkt_count", pkt_count, 32'(pkt_m));
            chk("evt_count", evt_count, 32'(evt_m));
            if (stall_prev) begin
                chk("stall_valid", {31'b0, m_tvalid}, 32'd1);
                chk("stall_data", m_tdata, prev_data);
                chk("stall_last", {31'b0, m_tlast}, {31'b0, prev_last});
            end
            if (out_fire) begin
                log_data.push_back(m_tdata);
                log_last.push_back(m_tlast);
                log_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("spurious_word", m_tdata, 32'hxxxxxxxx);
                end else begin
                    e = exp_q.pop_front();
                    exp_last = (e.kind == 3'd4) || (e.kind == 3'd3 && open_m == PE - 1);
                    chk("word_data", m_tdata, e.val);
                    chk("word_last", {31'b0, m_tlast}, {31'b0, exp_last});
                    if (e.kind == 3'd3) begin
                        evt_m++;
                        if (exp_last) begin open_m = 0; pkt_m++; end
                        else open_m++;
                    end else if (e.kind == 3'd4) begin
                        open_m = 0; pkt_m++;
                    end
                end
            end
            stall_prev = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
            if (in_fire) begin
                exp_q.push_back('{3'd0, muap_frame_No});
                exp_q.push_back('{3'd1, {20'h0, muap_ch}});
                exp_q.push_back('{3'd2, muap_ch_hash});
                exp_q.push_back('{3'd3, muap_data});
            end
            // An open packet closes after TO fully idle cycles with no arrivals.
            if (out_fire || in_fire || exp_q.size() != 0 || open_m == 0) begin
                idle_m = 0;
            end else begin
                idle_m++;
                if (idle_m == TO) begin
                    exp_q.push_back('{3'd4, {16'hFFFF, 16'(open_m)}});
                    idle_m = 0;
                end
            end
        end
    end

    task automatic set_event(input logic [31:0] f, input logic [11:0] c,
                             input logic [31:0] h, input logic [31:0] d);
        muap_frame_No = f; muap_ch = c; muap_ch_hash = h; muap_data = d;
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge with valid still high.
    task automatic send_event(input logic [31:0] f, input logic [11:0] c,
                              input logic [31:0] h, input logic [31:0] d);
        int g;
        bit hs;
        set_event(f, c, h, d);
        muap_valid = 1'b1;
        g = 0; hs = 0;
        while (!hs && g < 300) begin
            hs = muap_ready;
            @(posedge clk); #1;
            g++;
        end
        if (!hs) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_log(input int n, input int budget);
        int g;
        g = 0;
        while (log_data.size() < n && g < budget) begin
            @(posedge clk); #1;
            g++;
        end
        chk("wait_log_count", 32'(log_data.size() >= n), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        muap_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, muap_ready}, 32'd0);
        chk("rst_tvalid", {31'b0, m_tvalid}, 32'd0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_tlast", {31'b0, m_tlast}, 32'd0);
        chk("rst_pkt", pkt_count, 32'd0);
        chk("rst_evt", evt_count, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", {31'b0, muap_ready}, 32'd1);
        log_data.delete(); log_last.delete(); log_cyc.delete();
    endtask

    logic [31:0] ev_f[8], ev_h[8], ev_d[8];
    logic [11:0] ev_c[8];
    bit          done;

    initial begin
        int c0, acc, g, bubbles, lasts;
        rst = 1'b1; muap_valid = 1'b0; m_tready = 1'b1;
        set_event(32'd0, 12'd0, 32'd0, 32'd0);
        @(posedge clk); #1;

        // Single event: latency, word values, trailer timing.
        do_reset();
        m_tready = 1'b1;
        set_event(32'h100, 12'd5, 32'h03020100, 32'hDEADBEEF);
        muap_valid = 1'b1;
        @(posedge clk); #1;
        muap_valid = 1'b0;
        chk("lat_n1_tvalid", {31'b0, m_tvalid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_n2_tvalid", {31'b0, m_tvalid}, 32'd1);
        chk("lat_n2_w0", m_tdata, 32'h100);
        wait_log(5, 60);
        chk("s_w1", log_data[1], 32'h5);
        chk("s_w2", log_data[2], 32'h03020100);
        chk("s_w3", log_data[3], 32'hDEADBEEF);
        chk("s_w3_last", {31'b0, log_last[3]}, 32'd0);
        chk("s_trailer", log_data[4], 32'hFFFF0001);
        chk("s_trailer_last", {31'b0, log_last[4]}, 32'd1);
        chk("s_trailer_gap", 32'(log_cyc[4] - log_cyc[3]), 32'd9);
        @(posedge clk); #1;
        chk("s_pkt", pkt_count, 32'd1);
        chk("s_evt", evt_count, 32'd1);

        // Event arrives on the exact timeout cycle: no trailer, timer restarts.
        do_reset();
        send_event(32'h111, 12'd7, 32'h1, 32'h2);
        muap_valid = 1'b0;
        wait_log(4, 40);
        c0 = log_cyc[3];
        g = 0;
        while (cyc < c0 + 8 && g < 40) begin @(posedge clk); #1; g++; end
        set_event(32'h200, 12'd9, 32'h3, 32'h4);
        muap_valid = 1'b1;
        @(posedge clk); #1;
        muap_valid = 1'b0;
        wait_log(9, 60);
        chk("tb_no_trailer", log_data[4], 32'h200);
        chk("tb_w0_last", {31'b0, log_last[4]}, 32'd0);
        chk("tb_w3", log_data[7], 32'h4);
        chk("tb_trailer", log_data[8], 32'hFFFF0002);
        chk("tb_restart_gap", 32'(log_cyc[8] - log_cyc[7]), 32'd9);

        // Eight back-to-back events with 4-event packets.
        do_reset();
        for (int i = 0; i < 8; i++) send_event(32'h1000 + i, 12'(i), 32'hA0 + i, 32'hB0 + i);
        muap_valid = 1'b0;
        wait_log(32, 300);
        bubbles = 0; lasts = 0;
        for (int i = 1; i < 32; i++) if (log_cyc[i] != log_cyc[0] + i) bubbles++;
        for (int i = 0; i < 32; i++) if (log_last[i]) lasts++;
        chk("b2b_bubbles", 32'(bubbles), 32'd0);
        chk("b2b_last16", {31'b0, log_last[15]}, 32'd1);
        chk("b2b_last32", {31'b0, log_last[31]}, 32'd1);
        chk("b2b_last_total", 32'(lasts), 32'd2);
        repeat (20) @(posedge clk);
        #1;
        chk("b2b_no_trailer", 32'(log_data.size()), 32'd32);
        chk("b2b_pkt", pkt_count, 32'd2);
        chk("b2b_evt", evt_count, 32'd8);

        // Backpressure: downstream stalled with valid held for 40 cycles.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            ev_f[i] = $urandom; ev_c[i] = 12'($urandom); ev_h[i] = $urandom; ev_d[i] = $urandom;
        end
        m_tready = 1'b0;
        acc = 0;
        set_event(ev_f[0], ev_c[0], ev_h[0], ev_d[0]);
        muap_valid = 1'b1;
        repeat (40) begin
            bit hs;
            hs = muap_ready;
            @(posedge clk); #1;
            if (hs) begin
                acc++;
                set_event(ev_f[acc], ev_c[acc], ev_h[acc], ev_d[acc]);
            end
        end
        muap_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd5);
        chk("bp_ready_low", {31'b0, muap_ready}, 32'd0);
        chk("bp_tvalid", {31'b0, m_tvalid}, 32'd1);
        chk("bp_hold_w0", m_tdata, ev_f[0]);
        m_tready = 1'b1;
        wait_log(21, 200);
        chk("bp_first", log_data[0], ev_f[0]);
        chk("bp_ev2_hash", log_data[10], ev_h[2]);
        chk("bp_last_event", log_data[19], ev_d[4]);
        chk("bp_pkt_last", {31'b0, log_last[15]}, 32'd1);
        chk("bp_trailer", log_data[20], 32'hFFFF0001);

        // Random traffic with 50% downstream readiness.
        do_reset();
        done = 0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    send_event($urandom, 12'($urandom), $urandom, $urandom);
                    muap_valid = 1'b0;
                    repeat ($urandom_range(0, 12)) begin @(posedge clk); #1; end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    m_tready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        m_tready = 1'b1;
        g = 0;
        while ((exp_q.size() != 0 || m_tvalid) && g < 3000) begin @(posedge clk); #1; g++; end
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        chk("rand_evt", evt_count, 32'd200);

        // Asynchronous reset while W2 is presented with three events buffered.
        do_reset();
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) send_event(32'h300 + i, 12'(i), 32'h400 + i, 32'h500 + i);
        muap_valid = 1'b0;
        @(posedge clk); #1;
        m_tready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        m_tready = 1'b0;
        chk("rw_w2", m_tdata, 32'h400);
        #2;
        rst = 1'b1;
        #1;
        chk("rw_tvalid", {31'b0, m_tvalid}, 32'd0);
        chk("rw_pkt", pkt_count, 32'd0);
        chk("rw_evt", evt_count, 32'd0);
        chk("rw_ready", {31'b0, muap_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        log_data.delete(); log_last.delete(); log_cyc.delete();
        m_tready = 1'b1;
        send_event(32'h777, 12'hABC, 32'h888, 32'h999);
        muap_valid = 1'b0;
        wait_log(4, 40);
        chk("rw_clean_w0", log_data[0], 32'h777);
        chk("rw_clean_w1", log_data[1], 32'h00000ABC);
        chk("rw_clean_w2", log_data[2], 32'h888);
        chk("rw_clean_w3", log_data[3], 32'h999);
        chk("rw_clean_last", {31'b0, log_last[3]}, 32'd0);
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
